// File: rtl/icache.sv
// Direct-mapped, one-word-per-set instruction cache with a two-state miss FSM.
// A miss latches the word address and holds iREN until memory returns the fill word.
module icache #(
   parameter int unsigned SETS = 16
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload,
   output logic [15:0] miss_count
);

   localparam int unsigned IDX_W = $clog2(SETS);
   localparam int unsigned TAG_W = 30 - IDX_W;

   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } state_t;

   state_t                   state, next_state;
   logic [SETS-1:0]          valid;
   logic [TAG_W-1:0]         tag_arr  [SETS];
   logic [31:0]              data_arr [SETS];
   logic [29:0]              miss_word;
   logic [15:0]              miss_cnt;

   logic [IDX_W-1:0]         req_idx;
   logic [TAG_W-1:0]         req_tag;
   logic [IDX_W-1:0]         miss_idx;
   logic [TAG_W-1:0]         miss_tag;
   logic                     hit_c;
   logic                     latch_miss;
   logic                     fill;
   logic                     unused_offset;

   assign req_idx       = imemaddr[IDX_W+1:2];
   assign req_tag       = imemaddr[31:IDX_W+2];
   assign miss_idx      = miss_word[IDX_W-1:0];
   assign miss_tag      = miss_word[29:IDX_W];
   assign unused_offset = ^imemaddr[1:0];
   assign hit_c         = imemREN && valid[req_idx] && (tag_arr[req_idx] == req_tag);
   assign miss_count    = miss_cnt;

   // State register, valid bits, miss address and fill counter
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state     <= IDLE;
         valid     <= '0;
         miss_word <= '0;
         miss_cnt  <= '0;
      end else begin
         state <= next_state;
         if (latch_miss) miss_word <= imemaddr[31:2];
         if (fill) begin
            valid[miss_idx] <= 1'b1;
            if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
         end
      end
   end

   // Tag and data storage need no reset; valid gates every read
   always_ff @(posedge CLK) begin
      if (fill) begin
         tag_arr[miss_idx]  <= miss_tag;
         data_arr[miss_idx] <= iload;
      end
   end

   // Next state and outputs; everything is forced quiet while reset is low
   always_comb begin
      next_state = state;
      ihit       = 1'b0;
      imemload   = 32'h0;
      iREN       = 1'b0;
      iaddr      = 32'h0;
      latch_miss = 1'b0;
      fill       = 1'b0;
      if (nRST) begin
         case (state)
            IDLE: begin
               if (hit_c) begin
                  ihit     = 1'b1;
                  imemload = data_arr[req_idx];
               end else if (imemREN) begin
                  latch_miss = 1'b1;
                  next_state = FETCH;
               end
            end
            FETCH: begin
               iREN  = 1'b1;
               iaddr = {miss_word, 2'b00};
               if (!iwait) begin
                  fill       = 1'b1;
                  next_state = IDLE;
               end
            end
            default: next_state = IDLE;
         endcase
      end
   end

endmodule
